// File: rtl/lc3_pkg.sv
// Shared types and helpers for the LC-3 writeback slice.
package lc3_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam logic [2:0] CC_RESET = 3'b010;

    typedef struct packed {
        logic [WORD_W-1:0]     data;
        logic [REG_ADDR_W-1:0] dr;
        logic                  ld_reg;
        logic                  ld_cc;
    } wb_entry_t;

    // Returns {N, Z, P} for a result word; exactly one bit is set.
    function automatic logic [2:0] cc_of(input logic [WORD_W-1:0] word);
        logic neg;
        logic zero;
        neg  = word[WORD_W-1];
        zero = (word == '0);
        return {neg, zero, ~neg & ~zero};
    endfunction

endpackage

// File: rtl/lc3_writeback_if.sv
// Result-bus write request handshake into the writeback stage.
interface lc3_writeback_if #(
    parameter int DATA_W = 16
);
    import lc3_pkg::*;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_W-1:0]     wb_data;
    logic [REG_ADDR_W-1:0] wb_dr;
    logic                  wb_ld_reg;
    logic                  wb_ld_cc;

    modport master (
        output wb_valid, wb_data, wb_dr, wb_ld_reg, wb_ld_cc,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_data, wb_dr, wb_ld_reg, wb_ld_cc,
        output wb_ready
    );

endinterface

// File: rtl/lc3_wb_fifo.sv
// In-order circular queue of pending register-file writes.
module lc3_wb_fifo
    import lc3_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  wb_entry_t                            wr_entry,
    output wb_entry_t                            head,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [DEPTH-1:0]                     ent_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_dr,
    output logic [DEPTH-1:0]                     ent_ld_reg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign ent_valid = vld;

    always_comb begin
        ent_dr     = '0;
        ent_ld_reg = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_dr[i]     = mem[i].dr;
            ent_ld_reg[i] = mem[i].ld_reg;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: queues result writes, drives the register-file
// write port, and keeps NZP/BEN plus read-hazard flags.
module lc3_writeback
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3_writeback_if.slave        wb,
    input  logic                  hold,
    output logic [DATA_W-1:0]     REGin,
    output logic [REG_ADDR_W-1:0] DR,
    output logic                  LD_REG,
    input  logic [REG_ADDR_W-1:0] SR1,
    input  logic [REG_ADDR_W-1:0] SR2,
    output logic                  sr1_pending,
    output logic                  sr2_pending,
    input  logic [2:0]            ir_nzp,
    input  logic                  ld_ben,
    output logic                  N,
    output logic                  Z,
    output logic                  P,
    output logic                  BEN
);

    wb_entry_t                        wr_entry;
    wb_entry_t                        head;
    logic                             full;
    logic                             empty;
    logic [$clog2(DEPTH+1)-1:0]       count;
    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dr;
    logic [DEPTH-1:0]                 ent_ld_reg;
    logic                             push;
    logic                             retire;
    logic [2:0]                       cc_q;
    logic [2:0]                       cc_next;

    assign wb.wb_ready = (count < ($clog2(DEPTH+1))'(DEPTH));
    assign push        = wb.wb_valid & ~full;
    assign retire      = ~empty & ~hold;

    assign wr_entry = '{data: wb.wb_data, dr: wb.wb_dr,
                        ld_reg: wb.wb_ld_reg, ld_cc: wb.wb_ld_cc};

    lc3_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (retire),
        .wr_entry   (wr_entry),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ent_valid  (ent_valid),
        .ent_dr     (ent_dr),
        .ent_ld_reg (ent_ld_reg)
    );

    assign LD_REG = ~empty & head.ld_reg & ~hold;
    assign REGin  = empty ? '0 : head.data;
    assign DR     = empty ? '0 : head.dr;

    // BEN sees the CC value being written this same edge.
    assign cc_next   = (retire && head.ld_cc) ? cc_of(head.data) : cc_q;
    assign {N, Z, P} = cc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q <= CC_RESET;
            BEN  <= 1'b0;
        end else begin
            cc_q <= cc_next;
            if (ld_ben) begin
                BEN <= |(ir_nzp & cc_next);
            end
        end
    end

    always_comb begin
        sr1_pending = 1'b0;
        sr2_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_ld_reg[i] && (ent_dr[i] == SR1)) sr1_pending = 1'b1;
            if (ent_valid[i] && ent_ld_reg[i] && (ent_dr[i] == SR2)) sr2_pending = 1'b1;
        end
    end

endmodule

// File: tb/tb_lc3_writeback.sv
// Directed self-checking bench for lc3_writeback (DEPTH = 2).
module tb_lc3_writeback;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [15:0] REGin;
    logic [2:0]  DR;
    logic        LD_REG;
    logic [2:0]  SR1, SR2;
    logic        sr1_pending, sr2_pending;
    logic [2:0]  ir_nzp;
    logic        ld_ben;
    logic        N, Z, P, BEN;
    int          checks = 0;
    int          errors = 0;

    lc3_writeback_if #(.DATA_W(16)) wb_bus ();

    lc3_writeback #(.DATA_W(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .wb(wb_bus), .hold(hold),
        .REGin(REGin), .DR(DR), .LD_REG(LD_REG), .SR1(SR1), .SR2(SR2),
        .sr1_pending(sr1_pending), .sr2_pending(sr2_pending),
        .ir_nzp(ir_nzp), .ld_ben(ld_ben), .N(N), .Z(Z), .P(P), .BEN(BEN)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] dr,
                         input logic ldr, input logic ldc);
        wb_bus.wb_valid  = v;
        wb_bus.wb_data   = d;
        wb_bus.wb_dr     = dr;
        wb_bus.wb_ld_reg = ldr;
        wb_bus.wb_ld_cc  = ldc;
    endtask

    // Offers one request for exactly one edge (caller ensures there is room).
    task automatic push_one(input logic [15:0] d, input logic [2:0] dr,
                            input logic ldr, input logic ldc);
        drive(1'b1, d, dr, ldr, ldc);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (wb_bus.wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wb_bus.wb_ready); end
        checks++; if (LD_REG !== 1'b0) begin errors++; $display("FAIL reset_ld_reg: got %b expected 0", LD_REG); end
        checks++; if (REGin !== 16'h0 || DR !== 3'd0) begin errors++; $display("FAIL reset_port: got REGin=%h DR=%0d expected 0/0", REGin, DR); end
        checks++; if ({N, Z, P} !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b expected 010", {N, Z, P}); end
        checks++; if (BEN !== 1'b0) begin errors++; $display("FAIL reset_ben: got %b expected 0", BEN); end
    endtask

    task automatic test_single_write();
        SR1 = 3'd3; SR2 = 3'd7;
        push_one(16'h1234, 3'd3, 1'b1, 1'b1);
        checks++; if (LD_REG !== 1'b1) begin errors++; $display("FAIL single_ld_reg: got %b expected 1", LD_REG); end
        checks++; if (DR !== 3'd3 || REGin !== 16'h1234) begin errors++; $display("FAIL single_port: got DR=%0d REGin=%h expected 3/1234", DR, REGin); end
        checks++; if (sr1_pending !== 1'b1) begin errors++; $display("FAIL single_pending_before: got %b expected 1", sr1_pending); end
        tick();
        checks++; if ({N, Z, P} !== 3'b001) begin errors++; $display("FAIL single_nzp: got %b expected 001", {N, Z, P}); end
        checks++; if (LD_REG !== 1'b0 || wb_bus.wb_ready !== 1'b1) begin errors++; $display("FAIL single_empty: got LD_REG=%b ready=%b expected 0/1", LD_REG, wb_bus.wb_ready); end
        checks++; if (sr1_pending !== 1'b0 || sr2_pending !== 1'b0) begin errors++; $display("FAIL single_pending_after: got %b%b expected 00", sr1_pending, sr2_pending); end
    endtask

    task automatic test_backpressure();
        hold = 1'b1;
        push_one(16'h0001, 3'd1, 1'b1, 1'b0);
        push_one(16'h0002, 3'd2, 1'b1, 1'b0);
        checks++; if (wb_bus.wb_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", wb_bus.wb_ready); end
        checks++; if (LD_REG !== 1'b0) begin errors++; $display("FAIL bp_hold_ld_reg: got %b expected 0", LD_REG); end
        drive(1'b1, 16'h0003, 3'd3, 1'b1, 1'b0);
        tick();
        checks++; if (wb_bus.wb_ready !== 1'b0 || DR !== 3'd1) begin errors++; $display("FAIL bp_still_full: got ready=%b DR=%0d expected 0/1", wb_bus.wb_ready, DR); end
        hold = 1'b0;
        #1;
        checks++; if (LD_REG !== 1'b1 || REGin !== 16'h0001 || wb_bus.wb_ready !== 1'b0) begin errors++; $display("FAIL bp_retire1: got LD_REG=%b REGin=%h ready=%b expected 1/0001/0", LD_REG, REGin, wb_bus.wb_ready); end
        tick();
        checks++; if (wb_bus.wb_ready !== 1'b1 || REGin !== 16'h0002 || LD_REG !== 1'b1) begin errors++; $display("FAIL bp_retire2: got ready=%b REGin=%h LD_REG=%b expected 1/0002/1", wb_bus.wb_ready, REGin, LD_REG); end
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        checks++; if (REGin !== 16'h0003 || DR !== 3'd3 || LD_REG !== 1'b1) begin errors++; $display("FAIL bp_retire3: got REGin=%h DR=%0d LD_REG=%b expected 0003/3/1", REGin, DR, LD_REG); end
        tick();
        checks++; if (LD_REG !== 1'b0 || wb_bus.wb_ready !== 1'b1) begin errors++; $display("FAIL bp_drained: got LD_REG=%b ready=%b expected 0/1", LD_REG, wb_bus.wb_ready); end
        checks++; if ({N, Z, P} !== 3'b001) begin errors++; $display("FAIL bp_nzp_kept: got %b expected 001", {N, Z, P}); end
    endtask

    task automatic test_cc_signs();
        push_one(16'h8000, 3'd0, 1'b1, 1'b1);
        tick();
        checks++; if ({N, Z, P} !== 3'b100) begin errors++; $display("FAIL cc_neg: got %b expected 100", {N, Z, P}); end
        push_one(16'h0000, 3'd0, 1'b1, 1'b1);
        tick();
        checks++; if ({N, Z, P} !== 3'b010) begin errors++; $display("FAIL cc_zero: got %b expected 010", {N, Z, P}); end
        push_one(16'h7FFF, 3'd0, 1'b1, 1'b1);
        tick();
        checks++; if ({N, Z, P} !== 3'b001) begin errors++; $display("FAIL cc_pos: got %b expected 001", {N, Z, P}); end
        push_one(16'h8000, 3'd0, 1'b1, 1'b0);
        tick();
        checks++; if ({N, Z, P} !== 3'b001) begin errors++; $display("FAIL cc_no_ld: got %b expected 001", {N, Z, P}); end
    endtask

    task automatic test_ben_bypass();
        hold = 1'b1;
        push_one(16'hFFFF, 3'd4, 1'b0, 1'b1);
        hold = 1'b0; ir_nzp = 3'b100; ld_ben = 1'b1;
        tick();
        ld_ben = 1'b0;
        #1;
        checks++; if (BEN !== 1'b1) begin errors++; $display("FAIL ben_bypass: got %b expected 1", BEN); end
        checks++; if ({N, Z, P} !== 3'b100) begin errors++; $display("FAIL ben_bypass_nzp: got %b expected 100", {N, Z, P}); end
        push_one(16'h0001, 3'd4, 1'b0, 1'b1);
        tick();
        ld_ben = 1'b1;
        tick();
        ld_ben = 1'b0;
        #1;
        checks++; if (BEN !== 1'b0) begin errors++; $display("FAIL ben_no_retire: got %b expected 0 (nzp=%b)", BEN, {N, Z, P}); end
    endtask

    task automatic test_hazard();
        hold = 1'b1;
        push_one(16'h0055, 3'd5, 1'b1, 1'b0);
        push_one(16'h0022, 3'd2, 1'b0, 1'b0);
        SR1 = 3'd5; SR2 = 3'd2;
        #1;
        checks++; if (sr1_pending !== 1'b1 || sr2_pending !== 1'b0) begin errors++; $display("FAIL hazard_queued: got %b%b expected 10", sr1_pending, sr2_pending); end
        hold = 1'b0;
        #1;
        checks++; if (sr1_pending !== 1'b1) begin errors++; $display("FAIL hazard_retiring: got %b expected 1", sr1_pending); end
        tick();
        checks++; if (sr1_pending !== 1'b0 || sr2_pending !== 1'b0) begin errors++; $display("FAIL hazard_after: got %b%b expected 00", sr1_pending, sr2_pending); end
        tick();
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        push_one(16'h8000, 3'd1, 1'b0, 1'b1);
        hold = 1'b0; ir_nzp = 3'b100; ld_ben = 1'b1;
        tick();
        ld_ben = 1'b0; hold = 1'b1;
        #1;
        checks++; if ({N, Z, P, BEN} !== 4'b1001) begin errors++; $display("FAIL rmid_setup: got nzp_ben=%b expected 1001", {N, Z, P, BEN}); end
        push_one(16'h1111, 3'd6, 1'b1, 1'b1);
        push_one(16'h2222, 3'd7, 1'b1, 1'b1);
        checks++; if (wb_bus.wb_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b expected 0", wb_bus.wb_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0; hold = 1'b0;
        #1;
        checks++; if (wb_bus.wb_ready !== 1'b1 || {N, Z, P} !== 3'b010 || BEN !== 1'b0) begin errors++; $display("FAIL rmid_state: got ready=%b nzp=%b ben=%b expected 1/010/0", wb_bus.wb_ready, {N, Z, P}, BEN); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (LD_REG !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse: got LD_REG=%b cycle %0d expected 0", LD_REG, i); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; SR1 = '0; SR2 = '0; ir_nzp = '0; ld_ben = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_single_write();
        test_backpressure();
        test_cc_signs();
        test_ben_bypass();
        test_hazard();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
